adc_volt_monitor: RTL and testbench

//  Sits downstream of the AD9238 voltage-conversion stage.

---
 rtl/adc_pkg.sv | 26 ++
 rtl/adc_volt_monitor_if.sv | 33 +++
 rtl/adc_avg_chan.sv | 137 +++++++++++++
 rtl/adc_volt_monitor.sv | 85 ++++++++
 tb/tb_adc_volt_monitor.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_pkg.sv
// -----------------------------------------------------------------------------
// adc_pkg
// Shared definitions for the ADC voltage-monitor slice: sign-magnitude word
// layout, full-scale constant, over-voltage flag states and the
// sign-magnitude to two's-complement conversion used by every channel.
// No ports (package).
// -----------------------------------------------------------------------------
package adc_pkg;

    localparam int unsigned SM_SIGN_BIT       = 15;
    localparam int unsigned MV_W              = 16;
    localparam int          ADC_MV_FULL_SCALE = 5000;

    typedef enum logic {
        FLAG_LOW  = 1'b0,
        FLAG_HIGH = 1'b1
    } flag_state_t;

    // Negative zero (0x8000) negates a zero magnitude and therefore yields 0.
    function automatic logic signed [MV_W:0] sm_to_s17(input logic [MV_W-1:0] sm);
        logic signed [MV_W:0] mag;
        mag = {2'b00, sm[SM_SIGN_BIT-1:0]};
        return sm[SM_SIGN_BIT] ? -mag : mag;
    endfunction

endpackage

// File: rtl/adc_volt_monitor_if.sv
// -----------------------------------------------------------------------------
// adc_volt_monitor_if
// Groups the sample, control, threshold and result signals of the voltage
// monitor.
//   master : drives sample_en, clear, volt_ch1/2, thr_hi/lo; reads results
//   slave  : the monitor; reads inputs, drives avg_ch1/2, avg_valid, over_ch1/2
// -----------------------------------------------------------------------------
interface adc_volt_monitor_if;
    import adc_pkg::*;

    logic            sample_en;
    logic            clear;
    logic [MV_W-1:0] volt_ch1;
    logic [MV_W-1:0] volt_ch2;
    logic [MV_W-1:0] thr_hi;
    logic [MV_W-1:0] thr_lo;
    logic [MV_W-1:0] avg_ch1;
    logic [MV_W-1:0] avg_ch2;
    logic            avg_valid;
    logic            over_ch1;
    logic            over_ch2;

    modport master (
        output sample_en, clear, volt_ch1, volt_ch2, thr_hi, thr_lo,
        input  avg_ch1, avg_ch2, avg_valid, over_ch1, over_ch2
    );

    modport slave (
        input  sample_en, clear, volt_ch1, volt_ch2, thr_hi, thr_lo,
        output avg_ch1, avg_ch2, avg_valid, over_ch1, over_ch2
    );

endinterface

// File: rtl/adc_avg_chan.sv
// -----------------------------------------------------------------------------
// adc_avg_chan
// One monitor channel: sign-magnitude capture, block accumulator with
// floor-average and saturation, and a debounced hysteresis over-voltage flag.
// Ports:
//   ad_clk, rst_n  clock, async active-low reset
//   i_sample_en    capture i_volt into the stage-1 register
//   i_clear        synchronous restart (accumulator, average, flag)
//   i_acc_en       stage-1 register holds an accepted sample this cycle
//   i_last         that sample completes the block
//   i_volt         sign-magnitude mV
//   i_thr_hi/lo    signed set / release thresholds
//   o_avg          signed block average (held between blocks)
//   o_over         debounced over-threshold flag
// -----------------------------------------------------------------------------
module adc_avg_chan
    import adc_pkg::*;
#(
    parameter int unsigned AVG_LOG2 = 4,
    parameter int unsigned DEB_CNT  = 3
) (
    input  logic            ad_clk,
    input  logic            rst_n,
    input  logic            i_sample_en,
    input  logic            i_clear,
    input  logic            i_acc_en,
    input  logic            i_last,
    input  logic [MV_W-1:0] i_volt,
    input  logic [MV_W-1:0] i_thr_hi,
    input  logic [MV_W-1:0] i_thr_lo,
    output logic [MV_W-1:0] o_avg,
    output logic            o_over
);

    localparam int unsigned ACC_W = MV_W + AVG_LOG2 + 1;
    localparam logic [7:0]  DEB_LIM = 8'(DEB_CNT);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-MV_W+1){1'b0}}, {(MV_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-MV_W+1){1'b1}}, {(MV_W-1){1'b0}}};

    logic signed [MV_W:0]    r_s;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_shift;
    logic signed [MV_W-1:0]  w_avg;
    logic [MV_W-1:0]         r_avg;
    flag_state_t             r_state;
    flag_state_t             w_state_nxt;
    logic [7:0]              r_cnt;
    logic [7:0]              w_cnt_nxt;
    logic                    w_beyond;
    logic                    w_eval;

    // Stage 1: convert and hold the accepted sample.
    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s <= '0;
        end else if (i_sample_en && !i_clear) begin
            r_s <= sm_to_s17(i_volt);
        end
    end

    // Block sum includes the completing sample so nothing is lost on restart.
    assign w_sum   = r_acc + {{(ACC_W-MV_W-1){r_s[MV_W]}}, r_s};
    assign w_shift = w_sum >>> AVG_LOG2;
    assign w_eval  = i_acc_en && i_last;

    always_comb begin
        if (w_shift > SAT_MAX) begin
            w_avg = 16'sh7FFF;
        end else if (w_shift < SAT_MIN) begin
            w_avg = 16'sh8000;
        end else begin
            w_avg = w_shift[MV_W-1:0];
        end
    end

    // Stage 2: accumulate, publish on block completion.
    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_avg <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
            r_avg <= '0;
        end else if (i_acc_en) begin
            if (i_last) begin
                r_acc <= '0;
                r_avg <= w_avg;
            end else begin
                r_acc <= w_sum;
            end
        end
    end

    // Flag FSM: state register.
    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FLAG_LOW;
            r_cnt   <= '0;
        end else if (i_clear) begin
            r_state <= FLAG_LOW;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Flag FSM: next state, judged against the freshly computed average.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_beyond    = 1'b0;
        if (w_eval) begin
            case (r_state)
                FLAG_LOW:  w_beyond = (w_avg > $signed(i_thr_hi));
                FLAG_HIGH: w_beyond = (w_avg < $signed(i_thr_lo));
                default:   w_beyond = 1'b0;
            endcase
            if (w_beyond) begin
                w_cnt_nxt = r_cnt + 8'd1;
                if (w_cnt_nxt == DEB_LIM) begin
                    w_state_nxt = (r_state == FLAG_LOW) ? FLAG_HIGH : FLAG_LOW;
                    w_cnt_nxt   = '0;
                end
            end else begin
                w_cnt_nxt = '0;
            end
        end
    end

    assign o_avg  = r_avg;
    assign o_over = (r_state == FLAG_HIGH);

endmodule

// File: rtl/adc_volt_monitor.sv
// -----------------------------------------------------------------------------
// adc_volt_monitor
// Two-channel block averager with debounced over-voltage flags, downstream of
// the AD9238 voltage-conversion stage. Holds the shared sample counter and
// avg_valid generation; each channel's datapath lives in adc_avg_chan.
// Ports:
//   ad_clk  sample clock
//   rst_n   async active-low reset
//   bus     adc_volt_monitor_if.slave (sample_en, clear, volt_ch1/2,
//           thr_hi/lo in; avg_ch1/2, avg_valid, over_ch1/2 out)
// -----------------------------------------------------------------------------
module adc_volt_monitor
    import adc_pkg::*;
#(
    parameter int unsigned AVG_LOG2 = 4,
    parameter int unsigned DEB_CNT  = 3
) (
    input  logic               ad_clk,
    input  logic               rst_n,
    adc_volt_monitor_if.slave  bus
);

    logic                r_s_valid;
    logic [AVG_LOG2-1:0] r_cnt;
    logic                r_avg_valid;
    logic                w_last;

    // Counter tracks samples entering stage 2; all-ones marks the N-th.
    assign w_last = r_s_valid && (r_cnt == '1);

    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_valid   <= 1'b0;
            r_cnt       <= '0;
            r_avg_valid <= 1'b0;
        end else if (bus.clear) begin
            r_s_valid   <= 1'b0;
            r_cnt       <= '0;
            r_avg_valid <= 1'b0;
        end else begin
            r_s_valid   <= bus.sample_en;
            r_avg_valid <= w_last;
            if (r_s_valid) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.avg_valid = r_avg_valid;

    adc_avg_chan #(
        .AVG_LOG2 (AVG_LOG2),
        .DEB_CNT  (DEB_CNT)
    ) u_ch1 (
        .ad_clk      (ad_clk),
        .rst_n       (rst_n),
        .i_sample_en (bus.sample_en),
        .i_clear     (bus.clear),
        .i_acc_en    (r_s_valid),
        .i_last      (w_last),
        .i_volt      (bus.volt_ch1),
        .i_thr_hi    (bus.thr_hi),
        .i_thr_lo    (bus.thr_lo),
        .o_avg       (bus.avg_ch1),
        .o_over      (bus.over_ch1)
    );

    adc_avg_chan #(
        .AVG_LOG2 (AVG_LOG2),
        .DEB_CNT  (DEB_CNT)
    ) u_ch2 (
        .ad_clk      (ad_clk),
        .rst_n       (rst_n),
        .i_sample_en (bus.sample_en),
        .i_clear     (bus.clear),
        .i_acc_en    (r_s_valid),
        .i_last      (w_last),
        .i_volt      (bus.volt_ch2),
        .i_thr_hi    (bus.thr_hi),
        .i_thr_lo    (bus.thr_lo),
        .o_avg       (bus.avg_ch2),
        .o_over      (bus.over_ch2)
    );

endmodule

// File: tb/tb_adc_volt_monitor.sv
// -----------------------------------------------------------------------------
// tb_adc_volt_monitor
// Self-checking bench for adc_volt_monitor (AVG_LOG2=4, DEB_CNT=3) with a
// behavioural reference model: sample lists per block, floor division,
// and a debounce rule applied per produced average.
// -----------------------------------------------------------------------------
module tb_adc_volt_monitor;
    import adc_pkg::*;

    localparam int unsigned AVG_LOG2 = 4;
    localparam int unsigned DEB      = 3;
    localparam int          N        = 16;

    logic ad_clk = 1'b0;
    logic rst_n;
    always #5 ad_clk = ~ad_clk;

    adc_volt_monitor_if ifc ();

    adc_volt_monitor #(
        .AVG_LOG2 (AVG_LOG2),
        .DEB_CNT  (DEB)
    ) dut (
        .ad_clk (ad_clk),
        .rst_n  (rst_n),
        .bus    (ifc)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int due;
        int a1;
        int a2;
    } pend_t;

    int    q1[$];
    int    q2[$];
    pend_t pq[$];
    int    m_avg1, m_avg2, m_cnt1, m_cnt2;
    bit    m_valid, m_hi1, m_hi2;
    logic [34:0] obs;

    function automatic logic [15:0] sm(input int mv);
        if (mv < 0) return {1'b1, 15'(-mv)};
        return {1'b0, 15'(mv)};
    endfunction

    function automatic int sm_val(input logic [15:0] w);
        logic [14:0] mag;
        mag = w[14:0];
        return w[15] ? -int'(mag) : int'(mag);
    endfunction

    function automatic int floor_avg(input int q[$]);
        int s;
        int d;
        s = 0;
        foreach (q[i]) s += q[i];
        d = s / N;
        if ((s % N) != 0 && s < 0) d -= 1;
        return d;
    endfunction

    function automatic logic [34:0] expv();
        return {m_valid, m_hi1, m_hi2, 16'(m_avg1), 16'(m_avg2)};
    endfunction

    task automatic model_reset();
        q1.delete(); q2.delete(); pq.delete();
        m_avg1 = 0; m_avg2 = 0; m_cnt1 = 0; m_cnt2 = 0;
        m_valid = 0; m_hi1 = 0; m_hi2 = 0;
    endtask

    task automatic eval_flag(input int avg, inout bit hi, inout int cnt);
        int th;
        int tl;
        bit beyond;
        th = int'($signed(ifc.thr_hi));
        tl = int'($signed(ifc.thr_lo));
        beyond = hi ? (avg < tl) : (avg > th);
        cnt = beyond ? cnt + 1 : 0;
        if (cnt == int'(DEB)) begin
            hi  = !hi;
            cnt = 0;
        end
    endtask

    // Apply inputs for one edge and advance the model past that edge.
    task automatic drive(input bit en, input bit clr, input logic [15:0] v1,
                         input logic [15:0] v2);
        ifc.sample_en = en;
        ifc.clear     = clr;
        ifc.volt_ch1  = v1;
        ifc.volt_ch2  = v2;
        @(posedge ad_clk);
        #1;
        cyc++;
        if (clr) begin
            model_reset();
        end else begin
            m_valid = 0;
            if (pq.size() > 0 && pq[0].due == cyc) begin
                m_valid = 1;
                m_avg1  = pq[0].a1;
                m_avg2  = pq[0].a2;
                eval_flag(m_avg1, m_hi1, m_cnt1);
                eval_flag(m_avg2, m_hi2, m_cnt2);
                void'(pq.pop_front());
            end
            if (en) begin
                q1.push_back(sm_val(v1));
                q2.push_back(sm_val(v2));
                if (q1.size() == N) begin
                    pq.push_back('{cyc + 1, floor_avg(q1), floor_avg(q2)});
                    q1.delete();
                    q2.delete();
                end
            end
        end
        ifc.sample_en = 1'b0;
        ifc.clear     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifc.sample_en = 1'b0; ifc.clear = 1'b0;
        ifc.volt_ch1 = '0; ifc.volt_ch2 = '0;
        ifc.thr_hi = 16'h7FFF; ifc.thr_lo = 16'h8000;
        repeat (3) @(posedge ad_clk);
        #1;
        model_reset();
        obs = {ifc.avg_valid, ifc.over_ch1, ifc.over_ch2, ifc.avg_ch1, ifc.avg_ch2};
        checks++;
        if (obs !== 35'd0) begin
            errors++; $display("FAIL reset_state got=%h exp=%h", obs, 35'd0);
        end
        rst_n = 1'b1;
        repeat (2) begin
            drive(0, 0, '0, '0);
            obs = {ifc.avg_valid, ifc.over_ch1, ifc.over_ch2, ifc.avg_ch1, ifc.avg_ch2};
            checks++;
            if (obs !== expv()) begin
                errors++; $display("FAIL post_reset got=%h exp=%h", obs, expv());
            end
        end
    endtask

    task automatic test_const();
        logic [15:0] pat1[3] = '{16'h03E8, 16'h83E8, 16'h8000};
        logic [15:0] pat2[3] = '{16'h83E8, 16'h8000, 16'h03E8};
        logic [15:0] lit1[3] = '{16'd1000, 16'hFC18, 16'h0000};
        logic [15:0] lit2[3] = '{16'hFC18, 16'h0000, 16'd1000};
        drive(0, 1, '0, '0);
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < N; i++) begin
                drive(1, 0, pat1[p], pat2[p]);
                obs = {ifc.avg_valid, ifc.over_ch1, ifc.over_ch2, ifc.avg_ch1, ifc.avg_ch2};
                checks++;
                if (obs !== expv()) begin
                    errors++; $display("FAIL const_fill p=%0d i=%0d got=%h exp=%h", p, i, obs, expv());
                end
            end
            drive(0, 0, '0, '0);
            checks++;
            if (ifc.avg_valid !== 1'b1 || ifc.avg_ch1 !== lit1[p] || ifc.avg_ch2 !== lit2[p]) begin
                errors++;
                $display("FAIL const_avg p=%0d got=%b/%h/%h exp=1/%h/%h", p,
                         ifc.avg_valid, ifc.avg_ch1, ifc.avg_ch2, lit1[p], lit2[p]);
            end
            drive(0, 0, '0, '0);
            checks++;
            if (ifc.avg_valid !== 1'b0 || ifc.avg_ch1 !== lit1[p]) begin
                errors++;
                $display("FAIL const_hold p=%0d got=%b/%h exp=0/%h", p, ifc.avg_valid, ifc.avg_ch1, lit1[p]);
            end
        end
    endtask

    task automatic test_floor_gapped();
        drive(0, 1, '0, '0);
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < N; i++) begin
                drive(1, 0, (i % 2 == 0) ? 16'h0001 : 16'h8002,
                            (i % 2 == 0) ? 16'h0002 : 16'h8001);
                obs = {ifc.avg_valid, ifc.over_ch1, ifc.over_ch2, ifc.avg_ch1, ifc.avg_ch2};
                checks++;
                if (obs !== expv()) begin
                    errors++; $display("FAIL floor_on g=%0d i=%0d got=%h exp=%h", g, i, obs, expv());
                end
                for (int k = 0; k < (g == 0 ? 1 : 3); k++) begin
                    if (g == 0 && i != N - 1) break;
                    drive(0, 0, 16'($urandom), 16'($urandom));
                    obs = {ifc.avg_valid, ifc.over_ch1, ifc.over_ch2, ifc.avg_ch1, ifc.avg_ch2};
                    checks++;
                    if (obs !== expv()) begin
                        errors++; $display("FAIL floor_gap g=%0d i=%0d got=%h exp=%h", g, i, obs, expv());
                    end
                    if (i == N - 1 && k == 0) begin
                        checks++;
                        if (ifc.avg_valid !== 1'b1 || ifc.avg_ch1 !== 16'hFFFF || ifc.avg_ch2 !== 16'h0000) begin
                            errors++;
                            $display("FAIL floor_avg g=%0d got=%b/%h/%h exp=1/ffff/0000", g,
                                     ifc.avg_valid, ifc.avg_ch1, ifc.avg_ch2);
                        end
                    end
                end
            end
        end
    endtask

    task automatic run_block(input int a1, input int a2, input string tag);
        for (int i = 0; i < N; i++) begin
            drive(1, 0, sm(a1), sm(a2));
            obs = {ifc.avg_valid, ifc.over_ch1, ifc.over_ch2, ifc.avg_ch1, ifc.avg_ch2};
            checks++;
            if (obs !== expv()) begin
                errors++; $display("FAIL %s i=%0d got=%h exp=%h", tag, i, obs, expv());
            end
        end
        drive(0, 0, '0, '0);
    endtask

    task automatic test_flags();
        int  a1[14] = '{3100, 3100, 2900, 3100, 3100, 3100,
                        2500, 2500, 2500, 2500, 2500, 1900, 1900, 1900};
        bit  e1[14] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        bit  e2[14] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        drive(0, 1, '0, '0);
        ifc.thr_hi = 16'sd3000;
        ifc.thr_lo = 16'sd2000;
        for (int b = 0; b < 14; b++) begin
            run_block(a1[b], (b < 2) ? 3000 : 3001, "flag_fill");
            obs = {ifc.avg_valid, ifc.over_ch1, ifc.over_ch2, ifc.avg_ch1, ifc.avg_ch2};
            checks++;
            if (ifc.avg_valid !== 1'b1 || ifc.over_ch1 !== e1[b] || ifc.over_ch2 !== e2[b]
                || obs !== expv()) begin
                errors++;
                $display("FAIL flag_eval b=%0d got=%b/%b/%b exp=1/%b/%b", b,
                         ifc.avg_valid, ifc.over_ch1, ifc.over_ch2, e1[b], e2[b]);
            end
        end
    endtask

    task automatic test_clear();
        drive(0, 1, '0, '0);
        for (int b = 0; b < 3; b++) run_block(4000, 100, "clr_raise");
        checks++;
        if (ifc.over_ch1 !== 1'b1) begin
            errors++; $display("FAIL clr_raise got=%b exp=1", ifc.over_ch1);
        end
        drive(0, 1, '0, '0);
        obs = {ifc.avg_valid, ifc.over_ch1, ifc.over_ch2, ifc.avg_ch1, ifc.avg_ch2};
        checks++;
        if (obs !== 35'd0 || obs !== expv()) begin
            errors++; $display("FAIL clr_flag got=%h exp=%h", obs, 35'd0);
        end
        for (int i = 0; i < 7; i++) drive(1, 0, sm(int'($urandom_range(0, 30000))), sm(-9000));
        drive(1, 1, sm(30000), sm(30000));
        run_block(500, -500, "clr_fresh");
        checks++;
        if (ifc.avg_valid !== 1'b1 || ifc.avg_ch1 !== 16'd500 || ifc.avg_ch2 !== 16'hFE0C) begin
            errors++;
            $display("FAIL clr_fresh got=%b/%h/%h exp=1/01f4/fe0c", ifc.avg_valid, ifc.avg_ch1, ifc.avg_ch2);
        end
        for (int i = 0; i < N; i++) drive(1, 0, sm(1234), sm(1234));
        drive(0, 1, '0, '0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, '0, '0);
            obs = {ifc.avg_valid, ifc.over_ch1, ifc.over_ch2, ifc.avg_ch1, ifc.avg_ch2};
            checks++;
            if (obs !== 35'd0 || obs !== expv()) begin
                errors++; $display("FAIL clr_suppress i=%0d got=%h exp=%h", i, obs, 35'd0);
            end
        end
    endtask

    task automatic test_random();
        int  base1, base2, v1, v2;
        bit  en, clr;
        drive(0, 1, '0, '0);
        base1 = 0; base2 = 0;
        for (int c = 0; c < 1200; c++) begin
            if (c % 100 == 0) begin
                ifc.thr_hi = 16'(int'($urandom_range(0, 2000)) - 1000);
                ifc.thr_lo = 16'(int'($urandom_range(0, 2000)) - 1500);
            end
            if (c % 64 == 0) begin
                base1 = int'($urandom_range(0, 6000)) - 3000;
                base2 = int'($urandom_range(0, 6000)) - 3000;
            end
            v1 = base1 + int'($urandom_range(0, 1000)) - 500;
            v2 = base2 + int'($urandom_range(0, 1000)) - 500;
            if ($urandom_range(0, 7) == 0) v1 = int'($urandom_range(0, 65534)) - 32767;
            if ($urandom_range(0, 7) == 0) v2 = int'($urandom_range(0, 65534)) - 32767;
            en  = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 299) == 0);
            drive(en, clr, sm(v1), sm(v2));
            obs = {ifc.avg_valid, ifc.over_ch1, ifc.over_ch2, ifc.avg_ch1, ifc.avg_ch2};
            checks++;
            if (obs !== expv()) begin
                errors++; $display("FAIL random c=%0d got=%h exp=%h", c, obs, expv());
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 1, '0, '0);
        ifc.thr_hi = 16'sd3000;
        ifc.thr_lo = 16'sd2000;
        for (int b = 0; b < 3; b++) run_block(4000, 3500, "rst_prep");
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < (p == 0 ? 9 : N); i++) drive(1, 0, sm(-777), sm(777));
            #2;
            rst_n = 1'b0;
            #1;
            obs = {ifc.avg_valid, ifc.over_ch1, ifc.over_ch2, ifc.avg_ch1, ifc.avg_ch2};
            checks++;
            if (obs !== 35'd0) begin
                errors++; $display("FAIL rst_async p=%0d got=%h exp=%h", p, obs, 35'd0);
            end
            repeat (2) @(posedge ad_clk);
            #1;
            rst_n = 1'b1;
            model_reset();
            for (int i = 0; i < 4; i++) begin
                drive(0, 0, '0, '0);
                obs = {ifc.avg_valid, ifc.over_ch1, ifc.over_ch2, ifc.avg_ch1, ifc.avg_ch2};
                checks++;
                if (obs !== 35'd0) begin
                    errors++; $display("FAIL rst_no_pulse p=%0d i=%0d got=%h exp=%h", p, i, obs, 35'd0);
                end
            end
            run_block(700, -700, "rst_fresh");
            checks++;
            if (ifc.avg_valid !== 1'b1 || ifc.avg_ch1 !== 16'd700 || ifc.avg_ch2 !== 16'hFD44) begin
                errors++;
                $display("FAIL rst_fresh p=%0d got=%b/%h/%h exp=1/02bc/fd44", p,
                         ifc.avg_valid, ifc.avg_ch1, ifc.avg_ch2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_const();
        test_floor_gapped();
        test_flags();
        test_clear();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
